misc_opcode_encoder: RTL and testbench
======================================

Name: misc_opcode_encoder

Overview:
Transmit-side counterpart of the misc-opcode casez decoder. It accepts a 2-bit operation class plus a 1-bit modifier over a valid/ready handshake and encodes them into the 3-bit MiscOpcode_e wire format: A=000, B=10m, C=11m. Results are buffered in a small FIFO and presented downstream over a second valid/ready handshake. Illegal requests are dropped and flagged. The block sits in front of any consumer that decodes MiscOpcode_e with casez.

Parameters:
DEPTH, 2, FIFO entries; power of two, minimum 2.
CNT_W, 16, width of the saturating issued-opcode counter.

Ports:
clk  input  1  single clock; rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid and in_ready are both 1.
in_cls  input  2  class code, using the decoder's output encoding: 2'b11=A, 2'b10=B, 2'b00=C, 2'b01=illegal.
in_mod  input  1  modifier; becomes opcode bit 0 for B and C; must be 0 for A.
out_valid  output  1  encoded opcode valid.
out_ready  input  1  downstream accept.
out_opcode  output  3  encoded MiscOpcode_e.
err_illegal  output  1  sticky illegal-request flag.
err_clr  input  1  clears err_illegal.
issued_cnt  output  CNT_W  count of completed output handshakes, saturating.

Behaviour:
- Reset values while rst=1: FIFO empty, out_valid=0, out_opcode=3'b000, in_ready=0, err_illegal=0, issued_cnt=0. The first cycle after rst deasserts has in_ready=1.
- in_ready = (occupancy < DEPTH). It is registered-derived, and a same-cycle pop does not raise it.
- Encoding on accept:
  - A with mod=0 -> 000.
  - B -> {2'b10, in_mod}.
  - C -> {2'b11, in_mod}.
  - The block never emits 001 or 01x.
- Illegal request: cls=01, or A with in_mod=1.
  - The handshake completes (in_ready is honoured).
  - Nothing is enqueued.
  - err_illegal is set on the next edge.
- err_illegal holds until err_clr=1. If err_clr and a new illegal accept occur in the same cycle, err_illegal stays 1 (set wins).
- Latency: an opcode accepted at edge N drives out_valid=1 and out_opcode after edge N. There is no combinational in-to-out path.
- Output holds: while out_valid=1 and out_ready=0, out_opcode is held stable. out_valid never drops without a handshake.
- Ordering: strict FIFO order. Pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - When 0 < occupancy < DEPTH, occupancy is unchanged.
  - When full, only the pop occurs, because in_ready=0.
  - When empty, only the push occurs.
- When empty, out_valid=0 and out_opcode holds its last value (don't-care to consumers).
- issued_cnt increments on each out_valid & out_ready and saturates at 2^CNT_W-1.
- Reset asserted mid-operation flushes the FIFO immediately and asynchronously; all outputs return to their reset values.

Decomposition:
- Shared package (the existing package holding MiscOpcode_e), with these additions:
  - typedef enum logic [1:0] MiscCls_e {CLS_A=2'b11, CLS_B=2'b10, CLS_C=2'b00}.
  - Function encode_misc(cls, mod) returning MiscOpcode_e.
  - Function is_legal(cls, mod).
- The decoder and the bench reuse these functions.
- One sub-module, op_fifo: a parameterised synchronous FIFO with width 3, depth DEPTH, async active-high reset, and push/pop/full/empty/count. The encoding and error logic stay in the top module.

Test Plan:
- Reset, then send A(mod 0), B(mod 1), C(mod 0) with out_ready=1 -> out_opcode sequence 000, 101, 110, each one cycle after its accept; issued_cnt=3.
- out_ready=0, push B0, C1, then a third request -> in_ready=0 after 2 accepts and the third is stalled; release out_ready -> 100 then 110... wait, C1 -> 111. Required output: 100 then 111 in order, and the third request then drains.
- cls=01 and A with mod=1 -> neither appears at the output; err_illegal=1 from the next cycle; err_clr pulse -> 0; err_clr plus an illegal request in the same cycle -> stays 1.
- Round trip: all legal (cls, mod) pairs through this block into the casez decoder -> decoder output equals the original cls.
- CNT_W=2, 5 handshakes -> issued_cnt reads 1,2,3,3,3.
- Assert rst with the FIFO holding 2 entries and out_valid=1 -> out_valid=0 immediately (before the next clk edge); after release the FIFO is empty and issued_cnt=0.

Source files
------------

// File: rtl/misc_opcode_encoder_pkg.sv
// Shared misc-opcode definitions: wire encoding, class codes and the
// encode/legality/decode helpers used by encoder, decoder and benches.
package misc_opcode_encoder_pkg;

    // 3-bit MiscOpcode_e wire format: A=000, B=10m, C=11m
    typedef enum logic [2:0] {
        MISC_A  = 3'b000,
        MISC_B0 = 3'b100,
        MISC_B1 = 3'b101,
        MISC_C0 = 3'b110,
        MISC_C1 = 3'b111
    } MiscOpcode_e;

    // Class codes as produced by the casez decoder
    typedef enum logic [1:0] {
        CLS_A = 2'b11,
        CLS_B = 2'b10,
        CLS_C = 2'b00
    } MiscCls_e;

    localparam logic [1:0]  CLS_ILLEGAL = 2'b01;
    localparam int unsigned OPC_W       = 3;

    // A request is legal for classes A/B/C, with A additionally requiring mod=0
    function automatic logic is_legal(input logic [1:0] cls, input logic mod);
        logic ok;
        ok = 1'b0;
        case (cls)
            2'b11:        ok = ~mod;
            2'b10, 2'b00: ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Illegal inputs map to MISC_A; callers must gate with is_legal
    function automatic MiscOpcode_e encode_misc(input logic [1:0] cls, input logic mod);
        MiscOpcode_e op;
        op = MISC_A;
        case (cls)
            2'b10:   op = mod ? MISC_B1 : MISC_B0;
            2'b00:   op = mod ? MISC_C1 : MISC_C0;
            default: op = MISC_A;
        endcase
        return op;
    endfunction

    // Reference casez decoder: opcode back to class code
    function automatic logic [1:0] decode_misc(input logic [2:0] op);
        logic [1:0] cls;
        cls = CLS_A;
        casez (op)
            3'b0??:  cls = CLS_A;
            3'b10?:  cls = CLS_B;
            default: cls = CLS_C;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/misc_opcode_encoder_op_fifo.sv
// Parameterised synchronous FIFO with asynchronous active-high reset.
// Head entry is visible on dout whenever the FIFO is non-empty.
module op_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_en;
    logic             pop_en;

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    // Storage array: written at the write pointer on every push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/misc_opcode_encoder.sv
// Transmit-side misc-opcode encoder: class+modifier in, MiscOpcode_e out,
// buffered through op_fifo; illegal requests are consumed and flagged.
module misc_opcode_encoder
    import misc_opcode_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_cls,
    input  logic              in_mod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_opcode,
    output logic              err_illegal,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  issued_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [OPC_W-1:0] enc_bits;
    logic [OPC_W-1:0] fifo_head;
    logic [OPC_W-1:0] last_op;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             legal;
    logic             push;
    logic             pop;

    assign legal    = is_legal(in_cls, in_mod);
    assign enc_bits = encode_misc(in_cls, in_mod);

    // Ready comes only from registered occupancy, so a same-cycle pop cannot raise it
    assign in_ready  = ~rst & (fifo_count < DEPTH_C);
    assign accept    = in_valid & in_ready;
    assign push      = accept & legal & ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    // When empty, present the last popped opcode so the output does not glitch
    assign out_opcode = fifo_empty ? last_op : fifo_head;

    op_fifo #(
        .WIDTH (OPC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (enc_bits),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Remember the most recently delivered opcode for the empty-hold behaviour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_op <= '0;
        end else if (pop) begin
            last_op <= fifo_head;
        end
    end

    // Sticky illegal flag; a new illegal accept wins over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_illegal <= 1'b0;
        end else if (accept && !legal) begin
            err_illegal <= 1'b1;
        end else if (err_clr) begin
            err_illegal <= 1'b0;
        end
    end

    // Saturating count of completed output handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_cnt <= '0;
        end else if (pop && (issued_cnt != '1)) begin
            issued_cnt <= issued_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_misc_opcode_encoder.sv
// Directed self-checking bench for misc_opcode_encoder.
module tb_misc_opcode_encoder;
    import misc_opcode_encoder_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cls;
    logic        in_mod;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_opcode;
    logic        err_illegal;
    logic        err_clr;
    logic [15:0] issued_cnt;

    // Second instance with a narrow counter, sharing all inputs
    logic        c2_in_ready;
    logic        c2_out_valid;
    logic [2:0]  c2_out_opcode;
    logic        c2_err_illegal;
    logic [1:0]  c2_issued_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] rt_cls [5] = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b00};
    logic       rt_mod [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] rt_op  [5] = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    misc_opcode_encoder #(.DEPTH(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cls      (in_cls),
        .in_mod      (in_mod),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .err_illegal (err_illegal),
        .err_clr     (err_clr),
        .issued_cnt  (issued_cnt)
    );

    misc_opcode_encoder #(.DEPTH(2), .CNT_W(2)) dut_c2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (c2_in_ready),
        .in_cls      (in_cls),
        .in_mod      (in_mod),
        .out_valid   (c2_out_valid),
        .out_ready   (out_ready),
        .out_opcode  (c2_out_opcode),
        .err_illegal (c2_err_illegal),
        .err_clr     (err_clr),
        .issued_cnt  (c2_issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cls = 2'b00; in_mod = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_opcode", out_opcode, 3'b000);
        check("rst_err", err_illegal, 0);
        check("rst_cnt", issued_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // A0, B1, C0 streamed with out_ready=1
        out_ready = 1'b1;
        in_valid = 1'b1; in_cls = 2'b11; in_mod = 1'b0;
        tick();
        check("s1_valid", out_valid, 1);
        check("s1_op", out_opcode, 3'b000);
        check("s1_cnt", issued_cnt, 0);
        in_cls = 2'b10; in_mod = 1'b1;
        tick();
        check("s2_op", out_opcode, 3'b101);
        check("s2_cnt", issued_cnt, 1);
        in_cls = 2'b00; in_mod = 1'b0;
        tick();
        check("s3_op", out_opcode, 3'b110);
        check("s3_cnt", issued_cnt, 2);
        in_valid = 1'b0;
        tick();
        check("s4_valid", out_valid, 0);
        check("s4_hold_op", out_opcode, 3'b110);
        check("s4_cnt", issued_cnt, 3);

        // Backpressure: fill, stall third request, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_cls = 2'b10; in_mod = 1'b0;
        tick();
        check("bp1_ready", in_ready, 1);
        check("bp1_op", out_opcode, 3'b100);
        in_cls = 2'b00; in_mod = 1'b1;
        tick();
        check("bp2_ready", in_ready, 0);
        in_cls = 2'b11; in_mod = 1'b0;
        tick();
        check("bp3_ready", in_ready, 0);
        check("bp3_valid", out_valid, 1);
        check("bp3_hold_op", out_opcode, 3'b100);
        tick();
        check("bp4_hold_op", out_opcode, 3'b100);
        out_ready = 1'b1;
        tick();
        check("bp5_op", out_opcode, 3'b111);
        check("bp5_ready", in_ready, 1);
        tick();
        check("bp6_valid", out_valid, 1);
        check("bp6_op", out_opcode, 3'b000);
        in_valid = 1'b0;
        tick();
        check("bp7_valid", out_valid, 0);
        check("bp7_cnt", issued_cnt, 6);

        // Illegal requests and sticky error flag
        in_valid = 1'b1; in_cls = 2'b01; in_mod = 1'b0;
        tick();
        check("il1_err", err_illegal, 1);
        check("il1_valid", out_valid, 0);
        in_cls = 2'b11; in_mod = 1'b1;
        tick();
        check("il2_err", err_illegal, 1);
        check("il2_valid", out_valid, 0);
        in_valid = 1'b0; err_clr = 1'b1;
        tick();
        check("il3_clr", err_illegal, 0);
        in_valid = 1'b1; in_cls = 2'b01; in_mod = 1'b0;
        tick();
        check("il4_set_wins", err_illegal, 1);
        in_valid = 1'b0; err_clr = 1'b0;
        tick();
        check("il5_err", err_illegal, 1);
        check("il5_valid", out_valid, 0);
        check("il5_cnt", issued_cnt, 6);

        // Round trip through the casez decoder for every legal pair
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_cls = rt_cls[i]; in_mod = rt_mod[i];
            tick();
            in_valid = 1'b0;
            check("rt_valid", out_valid, 1);
            check("rt_op", out_opcode, rt_op[i]);
            check("rt_decode", decode_misc(out_opcode), rt_cls[i]);
            tick();
        end
        check("rt_cnt", issued_cnt, 11);

        // Asynchronous reset with two entries queued
        out_ready = 1'b0;
        in_valid = 1'b1; in_cls = 2'b10; in_mod = 1'b0;
        tick();
        in_cls = 2'b00; in_mod = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ar_full_ready", in_ready, 0);
        check("ar_valid_before", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid_async", out_valid, 0);
        check("ar_ready_async", in_ready, 0);
        check("ar_op_async", out_opcode, 3'b000);
        check("ar_err_async", err_illegal, 0);
        check("ar_cnt_async", issued_cnt, 0);
        tick();
        rst = 1'b0;
        #1;
        check("ar_ready_after", in_ready, 1);
        tick();
        check("ar_empty_after", out_valid, 0);
        check("ar_cnt_after", issued_cnt, 0);
        check("ar_c2_cnt_after", c2_issued_cnt, 0);

        // Saturation with CNT_W=2
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_cls = 2'b10; in_mod = 1'b0;
            tick();
            in_valid = 1'b0;
            tick();
            check("sat_c2_cnt", c2_issued_cnt, sat_exp[i]);
            check("sat_main_cnt", issued_cnt, i + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
